// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-resolution constants: default address width, sequential PC step,
// statistics counter width and the taken/not-taken encoding shared with the predictor.
package branch_resolve_unit_pkg;

  localparam int unsigned BRU_ADDR_W = 32;
  localparam int unsigned BRU_PC_INC = 4;
  localparam int unsigned BRU_STAT_W = 32;

  typedef enum logic {
    BR_NOT_TAKEN = 1'b0,
    BR_TAKEN     = 1'b1
  } br_dir_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID/EX branch bundle: stall and ID-stage branch info in, flush/redirect and
// predictor training out. master = pipeline side, slave = resolve unit.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = BRU_ADDR_W
);

  logic              stall;
  logic              id_branch;
  logic              id_predict;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_target;
  logic              ex_cond;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic              taken;
  logic              taken_valid;

  modport master (
    output stall, id_branch, id_predict, id_pc, id_target, ex_cond,
    input  flush, redirect_pc, taken, taken_valid
  );

  modport slave (
    input  stall, id_branch, id_predict, id_pc, id_target, ex_cond,
    output flush, redirect_pc, taken, taken_valid
  );

endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating event counter: +1 per cycle with inc_i high, sticks at all-ones.
// Synchronous active-low reset clears it.
module bru_sat_counter
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned WIDTH = BRU_STAT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve: holds the ID prediction into EX, flushes/redirects combinationally on mispredict,
// trains the predictor one cycle after EX. BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = BRU_ADDR_W,
  parameter int unsigned PC_INC = BRU_PC_INC
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef BRU_STATS_EN
  output logic [BRU_STAT_W-1:0] br_count_o,
  output logic [BRU_STAT_W-1:0] mispred_count_o,
`endif
  branch_resolve_unit_if.slave  bru
);

  logic              ex_valid;
  br_dir_e           ex_pred;
  logic [ADDR_W-1:0] ex_pc;
  logic [ADDR_W-1:0] ex_target;
  logic              mispredict;

  assign mispredict = ex_valid && (ex_pred != br_dir_e'(bru.ex_cond));

  // redirect_pc is forced to zero outside a flush so downstream can OR it freely
  always_comb begin
    bru.flush       = mispredict;
    bru.redirect_pc = '0;
    if (mispredict) begin
      bru.redirect_pc = (br_dir_e'(bru.ex_cond) == BR_TAKEN) ? ex_target
                                                              : ex_pc + ADDR_W'(PC_INC);
    end
  end

  // A flush squashes the wrong-path ID branch; a stall inserts a bubble
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid  <= 1'b0;
      ex_pred   <= BR_NOT_TAKEN;
      ex_pc     <= '0;
      ex_target <= '0;
    end else if (mispredict || bru.stall) begin
      ex_valid  <= 1'b0;
    end else begin
      ex_valid  <= bru.id_branch;
      ex_pred   <= br_dir_e'(bru.id_predict);
      ex_pc     <= bru.id_pc;
      ex_target <= bru.id_target;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bru.taken_valid <= 1'b0;
      bru.taken       <= 1'b0;
    end else begin
      bru.taken_valid <= ex_valid;
      if (ex_valid) begin
        bru.taken <= bru.ex_cond;
      end
    end
  end

`ifdef BRU_STATS_EN
  bru_sat_counter #(.WIDTH(BRU_STAT_W)) u_br_count (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (bru.taken_valid),
    .count_o (br_count_o)
  );

  bru_sat_counter #(.WIDTH(BRU_STAT_W)) u_mispred_count (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (mispredict),
    .count_o (mispred_count_o)
  );
`endif

endmodule
